fifo_rd_stream: RTL
===================

// Module: fifo_rd_stream
// PURPOSE
//  Downstream read stage of fifo_syn. Converts the FIFO's rden/valid pull interface into a
//  valid/ready stream with m_last framing every PKT_LEN beats.
//  Prefetches through a small credit-controlled skid buffer, so a stalled consumer never loses
//  data returned by the FIFO's registered read path.
// PARAMETERS
//  DWTH       8   data width; equals the fifo_syn FIFO_DWTH
//  SKID_AW    2   skid buffer address width; depth SKID_DEPTH = 2**SKID_AW entries
//  PKT_LEN    16  beats per packet; m_last is asserted on beat PKT_LEN-1; valid range 1..65535
// PORTS
//  clk         in   1     clock
//  rst         in   1     reset, synchronous, active-high
//  enable      in   1     1 = fetch from the FIFO; 0 = stop fetching and drain
//  fifo_empty  in   1     fifo_syn empty
//  fifo_rden   out  1     read request to fifo_syn
//  fifo_dout   in   DWTH  fifo_syn read data
//  fifo_valid  in   1     fifo_syn valid; fifo_dout is sampled in the same cycle
//  m_data      out  DWTH  stream data
//  m_valid     out  1     stream valid
//  m_ready     in   1     stream ready
//  m_last      out  1     last beat of a packet
//  busy        out  1     state != IDLE
//  err_ovf     out  1     sticky: fifo_valid arrived while the skid buffer was full
// BEHAVIOUR
//  Reset values: fifo_rden=0, m_valid=0, m_last=0, busy=0, err_ovf=0, m_data=0.
//   All counters and pointers reset to 0, state IDLE. Reset mid-packet discards in-flight and
//   buffered data and restarts the beat count at 0.
//  Credits:
//   - occ = skid occupancy (SKID_AW+1 bits); infl = reads issued but not yet returned (SKID_AW+1 bits).
//   - fifo_rden is a registered output, set to (state==RUN & !fifo_empty & (occ+infl+fifo_rden) < SKID_DEPTH).
//     The pending rden is counted, so back-to-back issue never overcommits.
//   - infl += 1 for each cycle fifo_rden=1; infl -= 1 for each cycle fifo_valid=1; both in the same cycle = no change.
//  Skid buffer: a circular buffer with SKID_DEPTH entries.
//   - Push on fifo_valid. Pop on m_valid & m_ready.
//   - Pointers wrap at SKID_DEPTH-1 -> 0.
//   - Push and pop in the same cycle leave occ unchanged, including when occ = SKID_DEPTH.
//   - A push into a full buffer without a same-cycle pop is dropped and sets err_ovf.
//     By the credit rule this cannot happen; err_ovf stays set until rst.
//  Output:
//   - m_valid = (occ != 0); m_data = head entry. Both are driven from buffer registers.
//   - Once m_valid is asserted, m_data stays stable until the handshake completes.
//   - Latency from fifo_valid to m_valid is 1 cycle when the buffer is empty.
//  Framing:
//   - beat counter bcnt (16 bits) increments on each handshake and wraps PKT_LEN-1 -> 0.
//   - m_last = m_valid & (bcnt == PKT_LEN-1).
//   - PKT_LEN=1: m_last=m_valid on every beat.
//  State machine:
//   - IDLE -> RUN when enable=1.
//   - RUN  -> STOP when enable=0. No new fifo_rden in STOP.
//   - STOP -> RUN when enable=1.
//   - STOP -> IDLE when infl==0 & occ==0.
//   - Outstanding reads are always absorbed and delivered. enable does not reset bcnt.
//  fifo_empty is trusted as-is. fifo_syn also gates rden with !empty, so a stale rden is harmless.
//   However, infl counts only rden actually issued while fifo_empty=0.
// TESTING
//  1. rst held 3 cycles mid-stream -> all outputs 0 on the next edge; bcnt=0; fifo_rden=0 until enable.
//  2. enable=1, FIFO holds 0x00..0x0F, m_ready=1, PKT_LEN=16 -> 16 beats in order;
//     m_last only on 0x0F; no bubbles once streaming.
//  3. m_ready=0 with 40 words in the FIFO -> exactly 4 reads issued, occ=4, fifo_rden stays 0;
//     m_ready=1 -> sequence continues in order; err_ovf=0.
//  4. m_ready toggles every cycle with the FIFO empty/refilled randomly, 1000 beats
//     -> scoreboard matches with no loss or duplication; m_last on every 16th beat.
//  5. enable drops with 2 reads in flight -> no further fifo_rden; both words delivered;
//     busy falls after the last handshake.
//  6. Force fifo_valid with occ=4 and m_ready=0 -> err_ovf=1 and stays 1 until rst.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - fifo_syn read stage: rden/valid pull to valid/ready stream with packet framing
module fifo_rd_stream #(
  parameter int DWTH    = 8,
  parameter int SKID_AW = 2,
  parameter int PKT_LEN = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            fifo_empty,
  output logic            fifo_rden,
  input  logic [DWTH-1:0] fifo_dout,
  input  logic            fifo_valid,
  output logic [DWTH-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic            busy,
  output logic            err_ovf
);

  localparam int                SKID_DEPTH = 2 ** SKID_AW;
  localparam logic [SKID_AW:0]  OCC_FULL   = (SKID_AW + 1)'(SKID_DEPTH);
  localparam logic [SKID_AW+1:0] CREDITS   = (SKID_AW + 2)'(SKID_DEPTH);
  localparam logic [15:0]       LAST_BEAT  = 16'(PKT_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t              state, state_nxt;
  logic [DWTH-1:0]     mem [SKID_DEPTH];
  logic [SKID_AW-1:0]  wptr, rptr;
  logic [SKID_AW:0]    occ, infl;
  logic [15:0]         bcnt;
  logic                pop, full, push_ok, issued;
  logic [SKID_AW+1:0]  committed;

  assign m_valid = (occ != '0);
  assign m_data  = mem[rptr];
  assign m_last  = m_valid && (bcnt == LAST_BEAT);
  assign busy    = (state != IDLE);

  always_comb begin
    pop       = m_valid && m_ready;
    full      = (occ == OCC_FULL);
    push_ok   = fifo_valid && (!full || pop);
    issued    = fifo_rden && !fifo_empty;
    // The read already requested this cycle holds a credit until it shows up in infl.
    committed = {1'b0, occ} + {1'b0, infl} + (SKID_AW + 2)'(fifo_rden);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = STOP;
      STOP: begin
        if (enable)                          state_nxt = RUN;
        else if (infl == '0 && occ == '0)    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fifo_rden <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      occ       <= '0;
      infl      <= '0;
      bcnt      <= '0;
      err_ovf   <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      // Gating on enable keeps the RUN->STOP edge from issuing one more read.
      fifo_rden <= (state == RUN) && enable && !fifo_empty && (committed < CREDITS);

      if (push_ok) begin
        mem[wptr] <= fifo_dout;
        wptr      <= wptr + 1'b1;
      end
      if (fifo_valid && full && !pop) err_ovf <= 1'b1;

      if (pop) begin
        rptr <= rptr + 1'b1;
        bcnt <= (bcnt == LAST_BEAT) ? 16'd0 : bcnt + 16'd1;
      end

      if (push_ok && !pop)      occ <= occ + 1'b1;
      else if (!push_ok && pop) occ <= occ - 1'b1;

      if (issued && !fifo_valid)                   infl <= infl + 1'b1;
      else if (!issued && fifo_valid && infl != '0) infl <= infl - 1'b1;
    end
  end

endmodule
